// File: rtl/scaler_bank_if.sv
// Readout bus of the scaler bank: channel address/strobe in, latched data and
// status flags out.
interface scaler_bank_if #(
  parameter int CW = 16
);
  logic [4:0]    scal_addr_i;
  logic          scal_rd_i;
  logic [CW-1:0] scal_dat_o;
  logic [CW-1:0] refpulse_cnt_o;
  logic          new_o;
  logic          overrun_o;

  // Reader side: drives address and strobe, observes data and flags.
  modport master (
    output scal_addr_i,
    output scal_rd_i,
    input  scal_dat_o,
    input  refpulse_cnt_o,
    input  new_o,
    input  overrun_o
  );

  // Scaler side: observes address and strobe, drives data and flags.
  modport slave (
    input  scal_addr_i,
    input  scal_rd_i,
    output scal_dat_o,
    output refpulse_cnt_o,
    output new_o,
    output overrun_o
  );
endinterface

// File: rtl/scaler_bank.sv
// Gated multi-channel edge scaler. Live counters accumulate rising edges over
// a gate; at gate end they are snapshotted into a shadow set. The shadow set
// is handed to the output set only while no read session is in progress, so
// a reader walking addresses 0..31 always sees one coherent snapshot.
module scaler_bank #(
  parameter int NCH       = 32,
  parameter int CW        = 16,
  parameter int GATE_CLKS = 33000000
) (
  input  logic           clk_i,
  input  logic           nrst_i,
  input  logic [NCH-1:0] trig_i,
  input  logic           refpulse_i,
  input  logic           pps_i,
  input  logic           pps_sel_i,
  scaler_bank_if.slave   rd_bus
);

  localparam int            TW         = (GATE_CLKS > 1) ? $clog2(GATE_CLKS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CLKS - 1);
  localparam logic [4:0]    ADDR_FIRST = 5'd0;
  localparam logic [4:0]    ADDR_LAST  = 5'd31;

  typedef enum logic {ST_IDLE, ST_SESSION} sess_state_t;

  // Channel NCH is the reference pulse; it shares the counter logic of the
  // discriminator channels.
  logic [NCH:0]  sig_in;
  logic [NCH:0]  sig_d_reg;
  logic [NCH:0]  sig_edge;

  logic          pps_d_reg;
  logic          pps_sel_d_reg;
  logic [TW-1:0] timer_reg;
  logic          sel_change;
  logic          pps_edge;
  logic          timer_last;
  logic          gate_end;

  sess_state_t   state_reg;
  sess_state_t   state_next;
  logic          session_active;
  logic          rd_start;
  logic          rd_end;

  logic          pending_reg;
  logic          new_reg;
  logic          overrun_reg;
  logic          transfer;
  logic [CW-1:0] dat_reg;
  logic [CW-1:0] out_val [NCH+1];

  assign sig_in   = {refpulse_i, trig_i};
  assign sig_edge = sig_in & ~sig_d_reg;

  // One-cycle delay of every counted input for rising-edge detection.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) sig_d_reg <= '0;
    else         sig_d_reg <= sig_in;
  end

  // Gate source: pps rising edge or terminal count of the internal timer.
  // A change of the gate source only restarts the timer, never ends a gate.
  assign sel_change = pps_sel_i ^ pps_sel_d_reg;
  assign pps_edge   = pps_i & ~pps_d_reg;
  assign timer_last = (timer_reg == TIMER_LAST);
  assign gate_end   = ~sel_change & (pps_sel_i ? pps_edge : timer_last);

  // pps edge delay, source-select tracking and the free-running gate timer.
  // The select delay follows the input during reset so that releasing reset
  // is never mistaken for a source change.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      pps_d_reg     <= 1'b0;
      pps_sel_d_reg <= pps_sel_i;
      timer_reg     <= '0;
    end else begin
      pps_d_reg     <= pps_i;
      pps_sel_d_reg <= pps_sel_i;
      if (sel_change || pps_sel_i || timer_last) timer_reg <= '0;
      else                                       timer_reg <= timer_reg + 1'b1;
    end
  end

  // Read session tracking: opened by a strobe at address 0, closed at 31.
  assign rd_start = rd_bus.scal_rd_i && (rd_bus.scal_addr_i == ADDR_FIRST);
  assign rd_end   = rd_bus.scal_rd_i && (rd_bus.scal_addr_i == ADDR_LAST);

  // Session state register.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Session next-state decode.
  always_comb begin
    state_next = state_reg;
    if (rd_start)    state_next = ST_SESSION;
    else if (rd_end) state_next = ST_IDLE;
  end

  // Session output decode.
  always_comb begin
    session_active = 1'b0;
    if (state_reg == ST_SESSION) session_active = 1'b1;
  end

  // The shadow set moves to the output set in the first idle cycle with a
  // snapshot waiting; the cycle of the closing strobe still counts as busy.
  assign transfer = pending_reg & ~session_active;

  // Snapshot bookkeeping: pending flag, fresh-data flag, sticky overrun.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      pending_reg <= 1'b0;
      new_reg     <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      pending_reg <= gate_end | (pending_reg & ~transfer);
      if (gate_end && pending_reg && !transfer) overrun_reg <= 1'b1;
      if (transfer)    new_reg <= 1'b1;
      else if (rd_end) new_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= NCH; gi++) begin : g_ch
      logic [CW-1:0] live_reg;
      logic [CW-1:0] shadow_reg;
      logic [CW-1:0] out_reg;

      // Saturating live count, gate-end snapshot and output hand-over. An
      // edge in the gate-end cycle belongs to the next gate.
      always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
          live_reg   <= '0;
          shadow_reg <= '0;
          out_reg    <= '0;
        end else begin
          if (gate_end) begin
            shadow_reg <= live_reg;
            live_reg   <= CW'(sig_edge[gi]);
          end else if (sig_edge[gi] && (live_reg != {CW{1'b1}})) begin
            live_reg <= live_reg + 1'b1;
          end
          if (transfer) out_reg <= shadow_reg;
        end
      end

      assign out_val[gi] = out_reg;
    end
  endgenerate

  // Registered readout of the addressed output entry, independent of strobe.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      dat_reg <= '0;
    end else if (int'(rd_bus.scal_addr_i) < NCH) begin
      dat_reg <= out_val[{1'b0, rd_bus.scal_addr_i}];
    end else begin
      dat_reg <= '0;
    end
  end

  assign rd_bus.scal_dat_o     = dat_reg;
  assign rd_bus.refpulse_cnt_o = out_val[NCH];
  assign rd_bus.new_o          = new_reg;
  assign rd_bus.overrun_o      = overrun_reg;

endmodule

// File: doc/scaler_bank.md
SCALER_BANK -- requirements
Module: scaler_bank

Interface
REQ-001 Parameter NCH, 32, number of scaler channels.
REQ-002 Parameter CW, 16, counter width in bits.
REQ-003 Parameter GATE_CLKS, 33000000, internal gate length in clk_i cycles.
REQ-004 clk_i  input  1  system clock (33 MHz); the only clock.
REQ-005 nrst_i  input  1  reset, synchronous to clk_i, active-low.
REQ-006 trig_i  input  NCH  discriminator outputs, already synchronous to clk_i.
REQ-007 refpulse_i  input  1  reference pulse, already synchronous to clk_i.
REQ-008 pps_i  input  1  external gate strobe, level, synchronous to clk_i.
REQ-009 pps_sel_i  input  1  1 = gate on pps_i rising edge; 0 = internal GATE_CLKS timer.
REQ-010 scal_addr_i  input  5  readout channel address.
REQ-011 scal_rd_i  input  1  one-cycle read strobe for the current address.
REQ-012 scal_dat_o  output  CW  registered readout data.
REQ-013 refpulse_cnt_o  output  CW  latched refpulse count.
REQ-014 new_o  output  1  fresh latched set available, not yet read.
REQ-015 overrun_o  output  1  sticky: a snapshot was overwritten before transfer.

Function
REQ-016 Each channel and refpulse SHALL detect rising edges as x & ~x_d, where x_d is x delayed one clk_i.
REQ-017 Each live counter SHALL increment by 1 per detected edge and saturate at 2^CW-1, with no wrap.
REQ-018 Gate end SHALL be the pps_i rising edge when pps_sel_i=1, else terminal count GATE_CLKS-1 of a free-running timer, which then wraps to 0.
REQ-019 On gate end, all live counts SHALL be copied to a shadow set in that cycle, excluding any edge in that cycle.
REQ-020 In the same gate-end cycle, live counters SHALL be set to 1 if an edge occurred that cycle, else to 0.
REQ-021 A read session SHALL start on scal_rd_i with scal_addr_i=0 and end on scal_rd_i with scal_addr_i=31.
REQ-022 The shadow-to-output transfer SHALL occur in the first cycle with no session active and a snapshot pending.
REQ-023 If a snapshot is pending at session end, the transfer SHALL occur in the cycle after the session-ending strobe.
REQ-024 A pending snapshot SHALL NOT be transferred while a session is active.
REQ-025 The transfer SHALL copy all NCH counts and the refpulse count in one cycle, set new_o=1, and clear the pending flag.
REQ-026 A gate end while a snapshot is pending SHALL overwrite the shadow set and set overrun_o=1.
REQ-027 overrun_o SHALL clear only on reset.
REQ-028 new_o SHALL clear on the session-ending strobe unless a transfer occurs in the same cycle; in that case the transfer wins.
REQ-029 scal_dat_o SHALL equal the output set entry [scal_addr_i], registered, with latency 1 cycle, independent of scal_rd_i.
REQ-030 refpulse_cnt_o SHALL be driven directly from the output set register.
REQ-031 Changing pps_sel_i SHALL reset the internal timer to 0 and SHALL NOT itself generate a gate end.

Reset
REQ-032 While nrst_i=0 at a clk_i edge, the following SHALL be cleared to 0: all live, shadow and output counters, the timer, edge-delay registers, the pending flag, the session flag, new_o, overrun_o and scal_dat_o.
REQ-033 Reset asserted mid-session or mid-gate SHALL abandon the session and snapshot.
REQ-034 After reset, the first gate SHALL start counting on the cycle after nrst_i=1.

Verification
REQ-035 Internal gate with GATE_CLKS=100 and 7 pulses on trig_i[3] -> after transfer, addr 3 reads 7 at 1-cycle latency; other channels read 0; new_o=1.
REQ-036 Ch 0 with 70000 edges in one gate -> addr 0 reads 0xFFFF.
REQ-037 Edge on ch 5 in the gate-end cycle -> snapshot excludes it; next gate's value includes it (count 1 if no others).
REQ-038 Gate end during a session (strobes at addr 0..15) -> output unchanged through addr 31; new data appears on the cycle after the addr-31 strobe; new_o=1.
REQ-039 Two gate ends during one session -> overrun_o=1; output holds the second snapshot; overrun_o stays 1 until nrst_i=0.
REQ-040 nrst_i=0 for 1 cycle mid-gate with pps_sel_i=1 -> all reads return 0 and new_o=0 until the next pps_i edge and transfer.
